// File: rtl/mfcc_pkg.sv
// Shared MFCC-chain constants: FFT size defaults, bin-keeping FSM states and
// the field positions of the complex {im, re} bin word.
package mfcc_pkg;

  localparam int LOG2_NFFT_DEF = 9;
  localparam int NFFT_DEF      = 1 << LOG2_NFFT_DEF;
  localparam int NBINS         = NFFT_DEF / 2 + 1;
  localparam int DATA_W_DEF    = 16;
  localparam int OUT_W_DEF     = 32;

  typedef enum logic {
    KEEP = 1'b0,
    DROP = 1'b1
  } bin_state_e;

  // LSB of the re (is_im=0) or im (is_im=1) field of a 2*dw-bit bin word.
  function automatic int field_lsb(input int dw, input bit is_im);
    return is_im ? dw : 0;
  endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |z|^2 pipeline: S1 captures re/im plus a tag, S2 holds re^2 and
// im^2; the output sum is formed combinationally from the S2 registers.
module cplx_mag_sq #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     valid_o,
  output logic [2*DATA_W-1:0]      mag_sq_o,
  output logic [TAG_W-1:0]         tag_o
);

  localparam int SQ_W = 2 * DATA_W - 1;

  logic                     v1_q, v2_q;
  logic signed [DATA_W-1:0] re_q, im_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q;
  logic [SQ_W-1:0]          re_sq_q, im_sq_q, re_sq_d, im_sq_d;
  logic signed [2*DATA_W-1:0] re_prod_s, im_prod_s;
  logic                     unused_sign_s;

  // Squares of a signed value are never negative, so the sign bit is dropped.
  always_comb begin
    re_prod_s     = (2*DATA_W)'(re_q) * (2*DATA_W)'(re_q);
    im_prod_s     = (2*DATA_W)'(im_q) * (2*DATA_W)'(im_q);
    re_sq_d       = re_prod_s[SQ_W-1:0];
    im_sq_d       = im_prod_s[SQ_W-1:0];
    unused_sign_s = re_prod_s[2*DATA_W-1] ^ im_prod_s[2*DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      re_sq_q <= '0;
      im_sq_q <= '0;
    end else if (en_i) begin
      v1_q    <= valid_i;
      re_q    <= re_i;
      im_q    <= im_i;
      tag1_q  <= tag_i;
      v2_q    <= v1_q;
      tag2_q  <= tag1_q;
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
    end
  end

  assign valid_o  = v2_q;
  assign tag_o    = tag2_q;
  assign mag_sq_o = {1'b0, re_sq_q} + {1'b0, im_sq_q};

endmodule

// File: rtl/power_spectrum_stream.sv
// Streaming power spectrum P[k] = (re^2 + im^2) / NFFT for bins 0..NFFT/2.
// Define POWSPEC_ROUND_EN for round-half-up instead of truncation.
module power_spectrum_stream
  import mfcc_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LOG2_NFFT = LOG2_NFFT_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [OUT_W-1:0]      m_tdata,
  output logic                  m_tlast,
  output logic [LOG2_NFFT-1:0]  m_bin,
  output logic                  frame_err
);

  localparam int TAG_W = LOG2_NFFT + 1;
  localparam int SUM_W = 2 * DATA_W;
  localparam int EXT_W = SUM_W + 1;
  localparam int RES_W = EXT_W - LOG2_NFFT;
  localparam int RE_LO = field_lsb(DATA_W, 1'b0);
  localparam int IM_LO = field_lsb(DATA_W, 1'b1);
  localparam logic [LOG2_NFFT-1:0] CNT_LAST = '1;
  localparam logic [LOG2_NFFT-1:0] CNT_HALF = LOG2_NFFT'(1) << (LOG2_NFFT - 1);

  bin_state_e           state_q, state_d;
  logic [LOG2_NFFT-1:0] cnt_q, cnt_d;
  logic                 err_d, frame_err_q;
  logic                 en_s, acc_s, keep_s;
  logic                 v2_s;
  logic [SUM_W-1:0]     sum_s;
  logic [TAG_W-1:0]     tag2_s;
  logic [EXT_W-1:0]     sum_ext_s;
  logic [RES_W-1:0]     res_s;
  logic [OUT_W-1:0]     sat_s;
  logic                 unused_lsb_s;
  logic                 m_tvalid_q, m_tlast_q;
  logic [OUT_W-1:0]     m_tdata_q;
  logic [LOG2_NFFT-1:0] m_bin_q;

  assign en_s     = !m_tvalid_q || m_tready;
  assign s_tready = en_s;
  assign acc_s    = s_tvalid && en_s;
  assign keep_s   = s_tvalid && (state_q == KEEP);

  // Frame tracking: any tlast or counter wrap restarts the frame; only the pair
  // (tlast on the final beat) is a clean end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (acc_s) begin
      if (s_tlast || (cnt_q == CNT_LAST)) begin
        cnt_d   = '0;
        state_d = KEEP;
        err_d   = !(s_tlast && (cnt_q == CNT_LAST));
      end else begin
        cnt_d = cnt_q + LOG2_NFFT'(1);
        if ((state_q == KEEP) && (cnt_q == CNT_HALF)) begin
          state_d = DROP;
        end else begin
          state_d = state_q;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= KEEP;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= err_d;
    end
  end

  cplx_mag_sq #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_mag_sq (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_s),
    .valid_i  (keep_s),
    .re_i     (s_tdata[RE_LO +: DATA_W]),
    .im_i     (s_tdata[IM_LO +: DATA_W]),
    .tag_i    ({cnt_q == CNT_HALF, cnt_q}),
    .valid_o  (v2_s),
    .mag_sq_o (sum_s),
    .tag_o    (tag2_s)
  );

  // Scale by 1/NFFT; the extra MSB keeps the rounding offset from overflowing.
  always_comb begin
`ifdef POWSPEC_ROUND_EN
    sum_ext_s = {1'b0, sum_s} + (EXT_W'(1) << (LOG2_NFFT - 1));
`else
    sum_ext_s = {1'b0, sum_s};
`endif
    res_s        = sum_ext_s[EXT_W-1:LOG2_NFFT];
    unused_lsb_s = ^sum_ext_s[LOG2_NFFT-1:0];
  end

  if (OUT_W >= RES_W) begin : g_nosat
    always_comb sat_s = OUT_W'(res_s);
  end else begin : g_sat
    always_comb begin
      if (|res_s[RES_W-1:OUT_W]) begin
        sat_s = '1;
      end else begin
        sat_s = res_s[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_bin_q    <= '0;
    end else if (en_s) begin
      m_tvalid_q <= v2_s;
      m_tdata_q  <= sat_s;
      m_tlast_q  <= v2_s && tag2_s[LOG2_NFFT];
      m_bin_q    <= tag2_s[LOG2_NFFT-1:0];
    end
  end

  assign m_tvalid  = m_tvalid_q;
  assign m_tdata   = m_tdata_q;
  assign m_tlast   = m_tlast_q;
  assign m_bin     = m_bin_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_power_spectrum_stream.sv
// Scoreboard bench for power_spectrum_stream (default build and POWSPEC_ROUND_EN).
module tb_power_spectrum_stream;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [8:0]  bin;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast, frame_err;
  logic [31:0] s_tdata, m_tdata;
  logic [8:0]  m_bin;
  logic        s2_tvalid, s2_tready, s2_tlast, m2_tvalid, m2_tready, m2_tlast, m2_err;
  logic [31:0] s2_tdata;
  logic [15:0] m2_tdata;
  logic [8:0]  m2_bin;

  power_spectrum_stream dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_bin(m_bin), .frame_err(frame_err)
  );

  power_spectrum_stream #(.DATA_W(16), .LOG2_NFFT(9), .OUT_W(16)) dut_sat (
    .clk(clk), .rst(rst), .s_tvalid(s2_tvalid), .s_tready(s2_tready), .s_tdata(s2_tdata),
    .s_tlast(s2_tlast), .m_tvalid(m2_tvalid), .m_tready(m2_tready), .m_tdata(m2_tdata),
    .m_tlast(m2_tlast), .m_bin(m2_bin), .frame_err(m2_err)
  );

  int checks = 0, errors = 0;
  int out_cnt = 0, tlast_cnt = 0, err_pulses = 0, cyc = 0;
  exp_t exp_q[$];
  int tb_cnt = 0;
  bit tb_keep = 1'b1;
  logic [31:0] last_tlast_data;
  logic [31:0] out_by_bin [0:511];
  logic [8:0]  last_bin;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  logic [8:0]  hold_bin;
  bit          bp_done;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] exp_pow(input int re, input int im, input int outw);
    longint s;
    s = longint'(re) * re + longint'(im) * im;
`ifdef POWSPEC_ROUND_EN
    s = s + 256;
`endif
    s = s >>> 9;
    if (s >= (longint'(1) << outw)) s = (longint'(1) << outw) - 1;
    return s[31:0];
  endfunction

  // Output monitor: scoreboard pop, stall stability and frame_err counting.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_pend) begin
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== hold_data || m_tlast !== hold_last || m_bin !== hold_bin) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b bin=%0d, want v=1 d=%h l=%b bin=%0d",
                   m_tvalid, m_tdata, m_tlast, m_bin, hold_data, hold_last, hold_bin);
        end
      end
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (m_tlast) begin
          tlast_cnt++;
          last_tlast_data = m_tdata;
        end
        out_by_bin[m_bin] = m_tdata;
        last_bin = m_bin;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got d=%h l=%b bin=%0d, want no output", m_tdata, m_tlast, m_bin);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tlast !== e.last || m_bin !== e.bin) begin
            errors++;
            $display("FAIL scoreboard: got d=%h l=%b bin=%0d, want d=%h l=%b bin=%0d",
                     m_tdata, m_tlast, m_bin, e.data, e.last, e.bin);
          end
        end
      end
      if (frame_err === 1'b1) err_pulses++;
      hold_pend = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      hold_data = m_tdata;
      hold_last = m_tlast;
      hold_bin  = m_bin;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic send_beat(input int re, input int im, input bit last);
    int guard = 0;
    bit acc = 1'b0;
    s_tdata  = {im[15:0], re[15:0]};
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      if (s_tready === 1'b1) acc = 1'b1;
      else guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no s_tready in %0d cycles, want acceptance", guard);
    end else begin
      if (tb_keep) exp_q.push_back('{data: exp_pow(re, im, 32), last: (tb_cnt == 256), bin: tb_cnt[8:0]});
      if (last || tb_cnt == 511) begin
        tb_cnt  = 0;
        tb_keep = 1'b1;
      end else begin
        if (tb_keep && tb_cnt == 256) tb_keep = 1'b0;
        tb_cnt++;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int tlast_at, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd) send_beat(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, k == tlast_at);
      else     send_beat(k, 0, k == tlast_at);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending outputs, want 0", exp_q.size());
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_bin !== 9'd0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b bin=%0d err=%b, want all 0",
               m_tvalid, m_tdata, m_tlast, m_bin, frame_err);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b, want 1", s_tready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_full_frame();
    int o0 = out_cnt, t0 = tlast_cnt, e0 = err_pulses, c0 = cyc;
    send_frame(512, 511, 1'b0);
    checks++;
    if (cyc - c0 != 512) begin
      errors++;
      $display("FAIL throughput: got %0d cycles, want 512", cyc - c0);
    end
    drain();
    checks++;
    if (out_cnt - o0 != 257 || tlast_cnt - t0 != 1 || err_pulses - e0 != 0) begin
      errors++;
      $display("FAIL full_frame_counts: got out=%0d tlast=%0d err=%0d, want 257 1 0",
               out_cnt - o0, tlast_cnt - t0, err_pulses - e0);
    end
    checks++;
    if (last_tlast_data !== 32'd128) begin
      errors++;
      $display("FAIL bin256_value: got %0d, want 128", last_tlast_data);
    end
  endtask

  task automatic test_single_bins();
    logic [31:0] want1;
`ifdef POWSPEC_ROUND_EN
    want1 = 32'd1;
`else
    want1 = 32'd0;
`endif
    for (int b = 0; b < 512; b++) out_by_bin[b] = 32'hDEAD_BEEF;
    send_beat(16384, 0, 1'b0);
    send_beat(1, 22, 1'b0);
    for (int k = 2; k < 512; k++) send_beat(0, 0, k == 511);
    drain();
    checks++;
    if (out_by_bin[0] !== 32'h0008_0000) begin
      errors++;
      $display("FAIL bin_16384: got %h, want 00080000", out_by_bin[0]);
    end
    checks++;
    if (out_by_bin[1] !== want1) begin
      errors++;
      $display("FAIL bin_sum485: got %h, want %h", out_by_bin[1], want1);
    end
  endtask

  task automatic test_saturate();
    int g = 0;
    s2_tdata  = 32'h8000_8000;
    s2_tlast  = 1'b0;
    s2_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s2_tvalid = 1'b0;
    while (m2_tvalid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (m2_tvalid !== 1'b1 || m2_tdata !== 16'hFFFF || m2_bin !== 9'd0) begin
      errors++;
      $display("FAIL saturate: got v=%b d=%h bin=%0d, want v=1 d=ffff bin=0", m2_tvalid, m2_tdata, m2_bin);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int o0 = out_cnt, t0 = tlast_cnt, e0 = err_pulses;
    bp_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(512, 511, 1'b1);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          m_tready = $urandom_range(0, 1);
        end
        m_tready = 1'b1;
      end
    join
    drain();
    checks++;
    if (out_cnt - o0 != 771 || tlast_cnt - t0 != 3 || err_pulses - e0 != 0) begin
      errors++;
      $display("FAIL backpressure_counts: got out=%0d tlast=%0d err=%0d, want 771 3 0",
               out_cnt - o0, tlast_cnt - t0, err_pulses - e0);
    end
  endtask

  task automatic test_early_tlast();
    int o0 = out_cnt, t0 = tlast_cnt, e0 = err_pulses;
    send_frame(101, 100, 1'b0);
    drain();
    checks++;
    if (out_cnt - o0 != 101 || tlast_cnt - t0 != 0 || err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL early_tlast_counts: got out=%0d tlast=%0d err=%0d, want 101 0 1",
               out_cnt - o0, tlast_cnt - t0, err_pulses - e0);
    end
    send_beat(7, 3, 1'b0);
    drain();
    checks++;
    if (last_bin !== 9'd0) begin
      errors++;
      $display("FAIL early_tlast_restart: got bin=%0d, want 0", last_bin);
    end
    for (int k = 1; k < 512; k++) send_beat(k, 0, k == 511);
    drain();
    checks++;
    if (err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL early_tlast_recover: got err=%0d, want 1", err_pulses - e0);
    end
  endtask

  task automatic test_missing_tlast();
    int o0 = out_cnt, t0 = tlast_cnt, e0 = err_pulses;
    send_frame(512, -1, 1'b1);
    drain();
    checks++;
    if (out_cnt - o0 != 257 || tlast_cnt - t0 != 1 || err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL missing_tlast_counts: got out=%0d tlast=%0d err=%0d, want 257 1 1",
               out_cnt - o0, tlast_cnt - t0, err_pulses - e0);
    end
    send_frame(512, 511, 1'b0);
    drain();
    checks++;
    if (out_cnt - o0 != 514 || err_pulses - e0 != 1) begin
      errors++;
      $display("FAIL missing_tlast_next: got out=%0d err=%0d, want 514 1", out_cnt - o0, err_pulses - e0);
    end
  endtask

  task automatic test_mid_reset();
    int o0, t0;
    send_frame(50, -1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tb_cnt  = 0;
    tb_keep = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_valid: got %b, want 0", m_tvalid);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    o0 = out_cnt;
    t0 = tlast_cnt;
    send_frame(512, 511, 1'b0);
    drain();
    checks++;
    if (out_cnt - o0 != 257 || tlast_cnt - t0 != 1) begin
      errors++;
      $display("FAIL mid_reset_frame: got out=%0d tlast=%0d, want 257 1", out_cnt - o0, tlast_cnt - t0);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0; m_tready = 1'b1;
    s2_tvalid = 1'b0; s2_tlast = 1'b0; s2_tdata = 32'h0; m2_tready = 1'b1;
    test_reset();
    test_full_frame();
    test_single_bins();
    test_saturate();
    test_backpressure();
    test_early_tlast();
    test_missing_tlast();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
